// File: rtl/multicycle_datapath_if.sv
// Memory-side bus of the multicycle datapath.
// Carries the instruction-fetch channel (imem_*) and the data-access channel
// (dmem_*). Both use a req/ready handshake: the requester holds req and its
// address/data until the responder raises ready.
//   master : datapath side (drives requests, receives ready/rdata)
//   slave  : memory side
interface multicycle_datapath_if #(
    parameter int N = 32
);
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ready;
    logic [N-1:0] imem_rdata;

    logic         dmem_req;
    logic         dmem_we;
    logic [N-1:0] dmem_addr;
    logic [N-1:0] dmem_wdata;
    logic         dmem_ready;
    logic [N-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle datapath: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) under a
// five-state FSM, with wait-state tolerant instruction/data memory access.
// Ports:
//   clk, reset        : clock; synchronous active-low reset
//   bus (master)      : imem/dmem req/ready channels
//   mem_to_reg .. reg_write, alu_control : decoder controls, held per instr
//   instr, pc         : instruction register and program counter
//   zero              : ALU result == 0, captured in the last EXEC
//   state             : FSM encoding (FETCH=0 .. WB=4)
//   retire            : high in the final cycle of each instruction
module multicycle_datapath #(
    parameter int N         = 32,
    parameter int R         = 7,
    parameter int PC_STEP   = 32,
    parameter int IMM_SHIFT = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_datapath_if.master bus,
    input  logic                 mem_to_reg,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 branch,
    input  logic                 jump,
    input  logic                 alu_src,
    input  logic                 reg_dst,
    input  logic                 reg_write,
    input  logic [3:0]           alu_control,
    output logic [N-1:0]         instr,
    output logic [N-1:0]         pc,
    output logic                 zero,
    output logic [2:0]           state,
    output logic                 retire
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t st, st_nx;

    logic [N-1:0] rf [2**R];
    logic [N-1:0] a_r, b_r, alu_r, mdr;

    // Register fields sit at fixed IR positions; narrower files use low bits.
    logic [R-1:0] rs, rt, rd, wa;
    logic [N-1:0] imm_x, imm_sh;
    assign rs     = instr[20 +: R];
    assign rt     = instr[13 +: R];
    assign rd     = instr[6  +: R];
    assign wa     = reg_dst ? rd : rt;
    assign imm_x  = {{(N-13){instr[12]}}, instr[12:0]};
    assign imm_sh = imm_x << IMM_SHIFT;

    logic [N-1:0] rd_a, rd_b;
    assign rd_a = (rs == '0) ? '0 : rf[rs];
    assign rd_b = (rt == '0) ? '0 : rf[rt];

    // ALU
    logic [N-1:0] b_op, alu_y;
    logic         alu_z;
    assign b_op = alu_src ? imm_x : b_r;

    always_comb begin
        alu_y = '0;
        case (alu_control)
            4'd0: alu_y = a_r + b_op;
            4'd1: alu_y = a_r - b_op;
            4'd2: alu_y = a_r & b_op;
            4'd3: alu_y = a_r | b_op;
            4'd4: alu_y = a_r ^ b_op;
            4'd5: alu_y = {{(N-1){1'b0}}, ($signed(a_r) < $signed(b_op))};
            4'd6: alu_y = a_r << b_op[4:0];
            4'd7: alu_y = a_r >> b_op[4:0];
            default: alu_y = '0;
        endcase
    end
    assign alu_z = (alu_y == '0);

    logic [N-1:0] pc_plus;
    assign pc_plus = pc + N'(PC_STEP);

    // Memory bus: address/data come straight from registers, so they are
    // inherently stable while a request waits.
    assign bus.imem_addr  = pc;
    assign bus.dmem_addr  = alu_r;
    assign bus.dmem_wdata = b_r;
    assign bus.dmem_we    = mem_write;
    assign state          = st;

    always_comb begin
        st_nx        = st;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        retire       = 1'b0;
        case (st)
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ready) st_nx = S_DECODE;
            end
            S_DECODE: st_nx = S_EXEC;
            S_EXEC: begin
                if (jump || branch) begin
                    retire = 1'b1;
                    st_nx  = S_FETCH;
                end else if (mem_read || mem_write) begin
                    st_nx = S_MEM;
                end else begin
                    st_nx = S_WB;
                end
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                if (bus.dmem_ready) begin
                    // A store (mem_write wins over mem_read) finishes here.
                    if (mem_write) begin
                        retire = 1'b1;
                        st_nx  = S_FETCH;
                    end else begin
                        st_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                retire = 1'b1;
                st_nx  = S_FETCH;
            end
            default: st_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st    <= S_FETCH;
            pc    <= '0;
            instr <= '0;
            a_r   <= '0;
            b_r   <= '0;
            alu_r <= '0;
            mdr   <= '0;
            zero  <= 1'b0;
            for (int i = 0; i < 2**R; i++) rf[i] <= '0;
        end else begin
            st <= st_nx;
            case (st)
                S_FETCH: if (bus.imem_ready) instr <= bus.imem_rdata;
                S_DECODE: begin
                    a_r <= rd_a;
                    b_r <= rd_b;
                end
                S_EXEC: begin
                    alu_r <= alu_y;
                    zero  <= alu_z;
                    // Branch uses this cycle's ALU result, not the old zero.
                    if (jump)        pc <= imm_sh;
                    else if (branch) pc <= alu_z ? (pc_plus + imm_sh) : pc_plus;
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        if (mem_write) pc  <= pc_plus;
                        else           mdr <= bus.dmem_rdata;
                    end
                end
                S_WB: begin
                    if (reg_write && wa != '0) rf[wa] <= mem_to_reg ? mdr : alu_r;
                    pc <= pc_plus;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: drives one instruction at a time with its
// decoder controls, models both memories with programmable wait states, and
// checks data-bus traffic against a scoreboard of expected accesses.
module tb_multicycle_datapath;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_to_reg, mem_read, mem_write, branch, jump;
    logic        alu_src, reg_dst, reg_write;
    logic [3:0]  alu_control;
    logic [31:0] instr, pc;
    logic        zero, retire;
    logic [2:0]  state;

    always #5 clk = ~clk;

    multicycle_datapath_if #(.N(32)) bus ();

    multicycle_datapath #(.N(32), .R(7), .PC_STEP(32), .IMM_SHIFT(5)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .alu_src(alu_src), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_control(alu_control),
        .instr(instr), .pc(pc), .zero(zero), .state(state), .retire(retire)
    );

    typedef struct packed {
        logic m2r, mrd, mwr, br, jmp, asrc, rdst, rwr;
        logic [3:0] op;
    } ctl_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
    } sb_t;

    sb_t sbq[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    logic [31:0] cur_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int rs, input int rt, input logic [12:0] lo);
        logic [6:0] s, t;
        s = rs[6:0];
        t = rt[6:0];
        return {5'b0, s, t, lo};
    endfunction

    function automatic ctl_t mkc(input logic [3:0] op, input logic asrc, input logic rdst,
                                 input logic rwr, input logic mrd, input logic mwr,
                                 input logic m2r, input logic br, input logic jmp);
        ctl_t c;
        c.op = op; c.asrc = asrc; c.rdst = rdst; c.rwr = rwr; c.mrd = mrd;
        c.mwr = mwr; c.m2r = m2r; c.br = br; c.jmp = jmp;
        return c;
    endfunction

    task automatic drive_ctl(input ctl_t c);
        mem_to_reg = c.m2r; mem_read = c.mrd; mem_write = c.mwr; branch = c.br;
        jump = c.jmp; alu_src = c.asrc; reg_dst = c.rdst; reg_write = c.rwr;
        alu_control = c.op;
    endtask

    // One instruction from its first FETCH cycle through retire.
    task automatic run(input string tag, input logic [31:0] iw, input ctl_t c,
                       input int idly, input int ddly, input logic [31:0] rdat,
                       input int exp_cyc, input logic [31:0] exp_pc);
        int cyc = 0, icnt = 0, dcnt = 0;
        bit done = 0, dseen = 0, dstable = 1, istable = 1;
        logic [31:0] da, dw;
        logic dwe;
        sb_t e;
        drive_ctl(c);
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus.imem_ready = 1'b0;
            bus.dmem_ready = 1'b0;
            bus.imem_rdata = 32'hBAD0_0000;
            bus.dmem_rdata = 32'hBAD0_0001;
            if (bus.imem_req) begin
                if (bus.imem_addr !== cur_pc) istable = 0;
                if (icnt == idly) begin
                    bus.imem_ready = 1'b1;
                    bus.imem_rdata = iw;
                end else icnt++;
            end
            if (bus.dmem_req) begin
                if (!dseen) begin
                    da = bus.dmem_addr; dw = bus.dmem_wdata; dwe = bus.dmem_we; dseen = 1;
                end else if (bus.dmem_addr !== da || bus.dmem_wdata !== dw || bus.dmem_we !== dwe)
                    dstable = 0;
                if (dcnt == ddly) begin
                    bus.dmem_ready = 1'b1;
                    bus.dmem_rdata = rdat;
                    if (sbq.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
                    else begin
                        e = sbq.pop_front();
                        chk({tag, "_daddr"}, bus.dmem_addr, e.addr);
                        chk({tag, "_dwe"}, {31'b0, bus.dmem_we}, {31'b0, e.we});
                        if (e.we) chk({tag, "_dwdata"}, bus.dmem_wdata, e.data);
                    end
                end else dcnt++;
            end
            #1;
            if (retire) done = 1;
        end
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        chk({tag, "_cycles"}, cyc, exp_cyc);
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_istable"}, {31'b0, istable}, 32'd1);
        if (dseen) chk({tag, "_dstable"}, {31'b0, dstable}, 32'd1);
        cur_pc = exp_pc;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic we);
        sb_t e;
        e.addr = a; e.data = d; e.we = we;
        sbq.push_back(e);
    endtask

    initial begin
        ctl_t ADDI, ST, LD, BR, JMP, RR;
        int mcyc;
        ADDI = mkc(4'd0, 1, 0, 1, 0, 0, 0, 0, 0);
        ST   = mkc(4'd0, 1, 0, 0, 0, 1, 0, 0, 0);
        LD   = mkc(4'd0, 1, 0, 1, 1, 0, 1, 0, 0);
        BR   = mkc(4'd1, 0, 0, 0, 0, 0, 0, 1, 0);
        JMP  = mkc(4'd0, 0, 0, 0, 0, 0, 0, 0, 1);
        RR   = mkc(4'd1, 0, 1, 1, 0, 0, 0, 0, 0);
        drive_ctl(mkc(4'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.imem_ready = 0; bus.dmem_ready = 0;
        bus.imem_rdata = '0; bus.dmem_rdata = '0;
        reset = 1'b0;
        cur_pc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {29'b0, state}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ir", instr, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_retire", {31'b0, retire}, 32'd0);
        chk("rst_dreq", {31'b0, bus.dmem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run("addi_r5", mk(0, 5, 13'd7), ADDI, 0, 0, 0, 4, 32'd32);
        push(32'd0, 32'd7, 1);
        run("st_r5", mk(0, 5, 13'd0), ST, 0, 0, 0, 4, 32'd64);
        run("beq_taken", mk(0, 0, 13'd2), BR, 0, 0, 0, 3, 32'd160);
        chk("beq_zero", {31'b0, zero}, 32'd1);
        run("beq_not", mk(5, 0, 13'd2), BR, 0, 0, 0, 3, 32'd192);
        chk("bne_zero", {31'b0, zero}, 32'd0);
        run("sub_r3", mk(5, 5, 13'(3 << 6)), RR, 0, 0, 0, 4, 32'd224);
        chk("sub_zero", {31'b0, zero}, 32'd1);
        run("wr_r0", mk(5, 0, 13'd7), ADDI, 0, 0, 0, 4, 32'd256);
        push(32'd0, 32'd0, 1);
        run("st_r0", mk(0, 0, 13'd0), ST, 0, 0, 0, 4, 32'd288);
        push(32'd4, 32'd0, 1);
        run("st_r3", mk(0, 3, 13'd4), ST, 0, 0, 0, 4, 32'd320);
        push(32'd11, 32'd0, 0);
        run("ld_r9", mk(5, 9, 13'd4), LD, 2, 3, 32'hDEADBEEF, 10, 32'd352);
        run("addi_r10", mk(0, 10, 13'h100), ADDI, 0, 0, 0, 4, 32'd384);
        // mem_read and mem_write together behave as a store
        push(32'h104, 32'hDEADBEEF, 1);
        run("st_r9", mk(10, 9, 13'd4), mkc(4'd0, 1, 0, 0, 1, 1, 0, 0, 0), 0, 0, 0, 4, 32'd416);
        run("addi_neg", mk(0, 12, 13'h1FFD), ADDI, 0, 0, 0, 4, 32'd448);
        run("slt_r13", mk(12, 5, 13'(13 << 6)), mkc(4'd5, 0, 1, 1, 0, 0, 0, 0, 0), 0, 0, 0, 4, 32'd480);
        run("sll_r11", mk(5, 11, 13'd4), mkc(4'd6, 1, 0, 1, 0, 0, 0, 0, 0), 0, 0, 0, 4, 32'd512);
        run("srl_r14", mk(12, 14, 13'd28), mkc(4'd7, 1, 0, 1, 0, 0, 0, 0, 0), 0, 0, 0, 4, 32'd544);
        push(32'd0, 32'd1, 1);
        run("st_r13", mk(0, 13, 13'd0), ST, 0, 0, 0, 4, 32'd576);
        push(32'd0, 32'd112, 1);
        run("st_r11", mk(0, 11, 13'd0), ST, 0, 1, 0, 5, 32'd608);
        push(32'd0, 32'h0000000F, 1);
        run("st_r14", mk(0, 14, 13'd0), ST, 0, 0, 0, 4, 32'd640);
        run("jmp_neg", mk(0, 0, 13'h1FFF), JMP, 0, 0, 0, 3, 32'hFFFFFFE0);
        run("pc_wrap", mk(5, 15, 13'd0), ADDI, 0, 0, 0, 4, 32'd0);

        // Abort a store stuck in MEM with reset.
        drive_ctl(ST);
        mcyc = 0;
        for (int i = 0; i < 20 && mcyc < 3; i++) begin
            @(negedge clk);
            bus.imem_ready = bus.imem_req;
            bus.imem_rdata = mk(0, 5, 13'd0);
            bus.dmem_ready = 1'b0;
            if (state == 3'd3) mcyc++;
        end
        chk("abort_in_mem", {29'b0, state}, 32'd3);
        chk("abort_dreq_pre", {31'b0, bus.dmem_req}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_dreq", {31'b0, bus.dmem_req}, 32'd0);
        chk("abort_state", {29'b0, state}, 32'd0);
        chk("abort_pc", pc, 32'd0);
        chk("abort_ir", instr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cur_pc = 32'd0;
        push(32'd0, 32'd0, 1);
        run("post_r5", mk(0, 5, 13'd0), ST, 0, 0, 0, 4, 32'd32);
        push(32'd0, 32'd0, 1);
        run("post_r9", mk(0, 9, 13'd0), ST, 0, 0, 0, 4, 32'd64);
        chk("sb_drained", sbq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
